// File: rtl/fight_data_control.sv
// fight_data_control: turn-based battle engine for the fight scene.
// Optional per-turn auto-confirm is compiled in with `define FIGHT_TURN_TIMEOUT_EN.
module fight_data_control #(
   parameter int unsigned TURN_TIMEOUT = 500_000_000,
   parameter logic [3:0]  FIGHT_SCENE  = 4'b0011
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] scene_state,
   input  logic       key_C,
   input  logic       key_L,
   input  logic       key_R,
   input  logic [7:0] p1_pokemon_hp,
   input  logic [7:0] p1_pokemon_speed,
   input  logic [7:0] p1_skill_1_damage,
   input  logic [7:0] p1_skill_2_damage,
   input  logic [7:0] p1_skill_3_damage,
   input  logic [7:0] p2_pokemon_hp,
   input  logic [7:0] p2_pokemon_speed,
   input  logic [7:0] p2_skill_1_damage,
   input  logic [7:0] p2_skill_2_damage,
   input  logic [7:0] p2_skill_3_damage,
   output logic [7:0] p1_hp_now,
   output logic [7:0] p2_hp_now,
   output logic       turn,
   output logic [1:0] skill_sel,
   output logic [7:0] last_damage,
   output logic       fight_done,
   output logic [1:0] winner
);

   // state  | meaning
   // IDLE   | outside the fight scene, waiting for an entry edge
   // LOAD   | capture HP, skills and first mover
   // SELECT | active player moves the skill cursor / confirms
   // APPLY  | subtract damage from the defender
   // CHECK  | defender knocked out -> DONE, else pass the turn
   // DONE   | battle over, outputs frozen until the scene changes
   typedef enum logic [2:0] {IDLE, LOAD, SELECT, APPLY, CHECK, DONE} state_t;

   state_t          state;
   logic            was_fight;
   logic            in_fight;
   logic            timed_out;
   logic [2:0][7:0] p1_sk;
   logic [2:0][7:0] p2_sk;
   logic [2:0][7:0] atk_sk;
   logic [7:0]      dmg;
   logic [7:0]      def_hp;
   logic [7:0]      hit_hp;

   if (TURN_TIMEOUT == 0) begin : g_bad_timeout
      $error("TURN_TIMEOUT must be nonzero");
   end

   assign in_fight = (scene_state == FIGHT_SCENE);
   assign atk_sk   = turn ? p2_sk : p1_sk;
   assign def_hp   = turn ? p1_hp_now : p2_hp_now;
   assign hit_hp   = (def_hp > dmg) ? def_hp - dmg : 8'd0;

   always_comb begin
      dmg = atk_sk[0];
      case (skill_sel)
         2'd2:    dmg = atk_sk[1];
         2'd3:    dmg = atk_sk[2];
         default: dmg = atk_sk[0];
      endcase
   end

`ifdef FIGHT_TURN_TIMEOUT_EN
   logic [31:0] timer;

   // Held at zero outside SELECT so every SELECT entry starts a fresh count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             timer <= '0;
      else if (state != SELECT)               timer <= '0;
      else if (!key_C && (key_L ^ key_R))     timer <= '0;
      else                                    timer <= timer + 32'd1;
   end

   assign timed_out = (timer == TURN_TIMEOUT);
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         was_fight   <= 1'b1;   // a fresh entry edge is required after reset
         p1_hp_now   <= '0;
         p2_hp_now   <= '0;
         turn        <= 1'b0;
         skill_sel   <= 2'd1;
         last_damage <= '0;
         fight_done  <= 1'b0;
         winner      <= 2'b00;
         p1_sk       <= '0;
         p2_sk       <= '0;
      end else begin
         was_fight <= in_fight;
         if (state != IDLE && !in_fight) begin
            state      <= IDLE;
            fight_done <= 1'b0;
         end else begin
            case (state)
               IDLE: if (in_fight && !was_fight) state <= LOAD;
               LOAD: begin
                  p1_hp_now   <= p1_pokemon_hp;
                  p2_hp_now   <= p2_pokemon_hp;
                  p1_sk       <= {p1_skill_3_damage, p1_skill_2_damage, p1_skill_1_damage};
                  p2_sk       <= {p2_skill_3_damage, p2_skill_2_damage, p2_skill_1_damage};
                  turn        <= (p2_pokemon_speed > p1_pokemon_speed);
                  skill_sel   <= 2'd1;
                  last_damage <= '0;
                  winner      <= 2'b00;
                  state       <= SELECT;
               end
               SELECT: begin
                  if (key_C || timed_out)  state     <= APPLY;
                  else if (key_R && !key_L) skill_sel <= (skill_sel == 2'd3) ? 2'd1 : skill_sel + 2'd1;
                  else if (key_L && !key_R) skill_sel <= (skill_sel == 2'd1) ? 2'd3 : skill_sel - 2'd1;
               end
               APPLY: begin
                  if (turn) p1_hp_now <= hit_hp;
                  else      p2_hp_now <= hit_hp;
                  last_damage <= dmg;
                  state       <= CHECK;
               end
               CHECK: begin
                  if (def_hp == 8'd0) begin
                     winner     <= turn ? 2'b10 : 2'b01;
                     fight_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     turn      <= ~turn;
                     skill_sel <= 2'd1;
                     state     <= SELECT;
                  end
               end
               DONE:    state <= DONE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fight_data_control.sv
// Self-checking bench for fight_data_control with a battle-level reference model.
module tb_fight_data_control;
   localparam logic [3:0] FIGHT = 4'b0011;
   localparam logic [3:0] OTHER = 4'b0010;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] scene_state = OTHER;
   logic       key_C = 1'b0, key_L = 1'b0, key_R = 1'b0;
   logic [7:0] p1_pokemon_hp, p1_pokemon_speed, p1_skill_1_damage, p1_skill_2_damage, p1_skill_3_damage;
   logic [7:0] p2_pokemon_hp, p2_pokemon_speed, p2_skill_1_damage, p2_skill_2_damage, p2_skill_3_damage;
   logic [7:0] p1_hp_now, p2_hp_now, last_damage;
   logic       turn, fight_done;
   logic [1:0] skill_sel, winner;

   int vectors = 0;
   int errors  = 0;

   // reference model state
   logic [7:0] m_hp1, m_hp2, m_last;
   logic       m_turn, m_done;
   logic [1:0] m_sel, m_winner;
   int         m_sk1 [3];
   int         m_sk2 [3];

   fight_data_control #(.TURN_TIMEOUT(20), .FIGHT_SCENE(FIGHT)) dut (
      .clk(clk), .reset(reset), .scene_state(scene_state),
      .key_C(key_C), .key_L(key_L), .key_R(key_R),
      .p1_pokemon_hp(p1_pokemon_hp), .p1_pokemon_speed(p1_pokemon_speed),
      .p1_skill_1_damage(p1_skill_1_damage), .p1_skill_2_damage(p1_skill_2_damage),
      .p1_skill_3_damage(p1_skill_3_damage),
      .p2_pokemon_hp(p2_pokemon_hp), .p2_pokemon_speed(p2_pokemon_speed),
      .p2_skill_1_damage(p2_skill_1_damage), .p2_skill_2_damage(p2_skill_2_damage),
      .p2_skill_3_damage(p2_skill_3_damage),
      .p1_hp_now(p1_hp_now), .p2_hp_now(p2_hp_now), .turn(turn), .skill_sel(skill_sel),
      .last_damage(last_damage), .fight_done(fight_done), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic c, input logic l, input logic r);
      key_C = c; key_L = l; key_R = r;
      tick();
      key_C = 1'b0; key_L = 1'b0; key_R = 1'b0;
   endtask

   task automatic common_stats();
      p1_pokemon_hp = 8'd50; p1_pokemon_speed = 8'd200;
      p1_skill_1_damage = 8'd30; p1_skill_2_damage = 8'd40; p1_skill_3_damage = 8'd50;
      p2_pokemon_hp = 8'd60; p2_pokemon_speed = 8'd150;
      p2_skill_1_damage = 8'd30; p2_skill_2_damage = 8'd40; p2_skill_3_damage = 8'd50;
   endtask

   // Leave the scene, re-enter, and stop on the first SELECT cycle.
   task automatic enter_fight();
      scene_state = OTHER;
      tick();
      scene_state = FIGHT;
      tick();
      tick();
   endtask

   task automatic m_load();
      m_hp1 = p1_pokemon_hp; m_hp2 = p2_pokemon_hp;
      m_sk1[0] = p1_skill_1_damage; m_sk1[1] = p1_skill_2_damage; m_sk1[2] = p1_skill_3_damage;
      m_sk2[0] = p2_skill_1_damage; m_sk2[1] = p2_skill_2_damage; m_sk2[2] = p2_skill_3_damage;
      m_turn = (p2_pokemon_speed > p1_pokemon_speed);
      m_sel = 2'd1; m_last = 8'd0; m_winner = 2'b00; m_done = 1'b0;
   endtask

   task automatic m_move(input logic l, input logic r);
      int s;
      s = m_sel;
      if (r && !l) s = s % 3 + 1;
      if (l && !r) s = (s + 1) % 3 + 1;
      m_sel = 2'(s);
   endtask

   task automatic m_attack();
      int d;
      d = m_turn ? m_sk2[m_sel - 1] : m_sk1[m_sel - 1];
      m_last = 8'(d);
      if (m_turn) m_hp1 = (int'(m_hp1) > d) ? 8'(int'(m_hp1) - d) : 8'd0;
      else        m_hp2 = (int'(m_hp2) > d) ? 8'(int'(m_hp2) - d) : 8'd0;
      if ((m_turn ? m_hp1 : m_hp2) == 8'd0) begin
         m_winner = m_turn ? 2'b10 : 2'b01;
         m_done   = 1'b1;
      end else begin
         m_turn = ~m_turn;
         m_sel  = 2'd1;
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      vectors++; if (p1_hp_now !== 8'd0) begin errors++; $display("FAIL reset_p1_hp got %0d exp 0", p1_hp_now); end
      vectors++; if (p2_hp_now !== 8'd0) begin errors++; $display("FAIL reset_p2_hp got %0d exp 0", p2_hp_now); end
      vectors++; if (turn !== 1'b0) begin errors++; $display("FAIL reset_turn got %0d exp 0", turn); end
      vectors++; if (skill_sel !== 2'd1) begin errors++; $display("FAIL reset_sel got %0d exp 1", skill_sel); end
      vectors++; if (last_damage !== 8'd0) begin errors++; $display("FAIL reset_last got %0d exp 0", last_damage); end
      vectors++; if (fight_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", fight_done); end
      vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %0d exp 0", winner); end
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic test_full_battle();
      common_stats();
      enter_fight();
      vectors++; if (turn !== 1'b0) begin errors++; $display("FAIL full_first_turn got %0d exp 0", turn); end
      vectors++; if (p1_hp_now !== 8'd50 || p2_hp_now !== 8'd60) begin errors++; $display("FAIL full_load_hp got %0d/%0d exp 50/60", p1_hp_now, p2_hp_now); end
      press(0, 0, 1);
      press(0, 0, 1);
      vectors++; if (skill_sel !== 2'd3) begin errors++; $display("FAIL full_sel got %0d exp 3", skill_sel); end
      press(1, 0, 0);
      tick();
      vectors++; if (p2_hp_now !== 8'd10) begin errors++; $display("FAIL full_p2_hp1 got %0d exp 10", p2_hp_now); end
      vectors++; if (last_damage !== 8'd50) begin errors++; $display("FAIL full_last1 got %0d exp 50", last_damage); end
      tick();
      vectors++; if (turn !== 1'b1) begin errors++; $display("FAIL full_turn_p2 got %0d exp 1", turn); end
      press(1, 0, 0);
      tick();
      vectors++; if (p1_hp_now !== 8'd20) begin errors++; $display("FAIL full_p1_hp got %0d exp 20", p1_hp_now); end
      tick();
      vectors++; if (turn !== 1'b0) begin errors++; $display("FAIL full_turn_p1 got %0d exp 0", turn); end
      press(1, 0, 0);
      tick();
      vectors++; if (p2_hp_now !== 8'd0) begin errors++; $display("FAIL full_p2_sat got %0d exp 0", p2_hp_now); end
      vectors++; if (fight_done !== 1'b0) begin errors++; $display("FAIL full_done_early got %0d exp 0", fight_done); end
      tick();
      vectors++; if (winner !== 2'b01) begin errors++; $display("FAIL full_winner got %0d exp 1", winner); end
      vectors++; if (fight_done !== 1'b1) begin errors++; $display("FAIL full_done got %0d exp 1", fight_done); end
      press(0, 0, 1);
      press(1, 0, 0);
      tick();
      vectors++; if (skill_sel !== 2'd1 || p1_hp_now !== 8'd20) begin errors++; $display("FAIL full_done_hold got sel %0d hp %0d exp 1/20", skill_sel, p1_hp_now); end
   endtask

   task automatic test_abort();
      scene_state = OTHER;
      tick();
      vectors++; if (fight_done !== 1'b0) begin errors++; $display("FAIL abort_done_clear got %0d exp 0", fight_done); end
      vectors++; if (winner !== 2'b01 || p2_hp_now !== 8'd0) begin errors++; $display("FAIL abort_hold got winner %0d hp %0d exp 1/0", winner, p2_hp_now); end
      enter_fight();
      vectors++; if (winner !== 2'b00) begin errors++; $display("FAIL abort_winner_clr got %0d exp 0", winner); end
      vectors++; if (p1_hp_now !== 8'd50 || p2_hp_now !== 8'd60) begin errors++; $display("FAIL abort_reload got %0d/%0d exp 50/60", p1_hp_now, p2_hp_now); end
      press(1, 0, 0);
      tick(); tick();
      scene_state = OTHER;
      tick();
      press(1, 0, 0);
      tick(); tick();
      vectors++; if (p1_hp_now !== 8'd50 || p2_hp_now !== 8'd30) begin errors++; $display("FAIL abort_idle_hold got %0d/%0d exp 50/30", p1_hp_now, p2_hp_now); end
      enter_fight();
      vectors++; if (p2_hp_now !== 8'd60) begin errors++; $display("FAIL abort_reenter got %0d exp 60", p2_hp_now); end
   endtask

   task automatic test_speed_tie();
      common_stats();
      p2_pokemon_speed = 8'd200;
      enter_fight();
      vectors++; if (turn !== 1'b0) begin errors++; $display("FAIL tie_equal got %0d exp 0", turn); end
      p2_pokemon_speed = 8'd201;
      enter_fight();
      vectors++; if (turn !== 1'b1) begin errors++; $display("FAIL tie_faster got %0d exp 1", turn); end
      common_stats();
   endtask

   task automatic test_skill_wrap();
      common_stats();
      enter_fight();
      press(0, 1, 0);
      vectors++; if (skill_sel !== 2'd3) begin errors++; $display("FAIL wrap_left got %0d exp 3", skill_sel); end
      press(0, 0, 1);
      vectors++; if (skill_sel !== 2'd1) begin errors++; $display("FAIL wrap_right got %0d exp 1", skill_sel); end
      press(0, 0, 1);
      press(0, 1, 1);
      vectors++; if (skill_sel !== 2'd2) begin errors++; $display("FAIL wrap_lr got %0d exp 2", skill_sel); end
      press(1, 0, 1);
      tick();
      vectors++; if (p2_hp_now !== 8'd20 || last_damage !== 8'd40) begin errors++; $display("FAIL wrap_cr got hp %0d dmg %0d exp 20/40", p2_hp_now, last_damage); end
   endtask

   task automatic test_async_reset();
      common_stats();
      enter_fight();
      press(1, 0, 0);
      #1 reset = 1'b0;
      #1;
      vectors++; if (p1_hp_now !== 8'd0 || p2_hp_now !== 8'd0) begin errors++; $display("FAIL arst_hp got %0d/%0d exp 0/0", p1_hp_now, p2_hp_now); end
      vectors++; if (last_damage !== 8'd0 || skill_sel !== 2'd1 || turn !== 1'b0) begin errors++; $display("FAIL arst_regs got dmg %0d sel %0d turn %0d exp 0/1/0", last_damage, skill_sel, turn); end
      #1 reset = 1'b1;
      repeat (5) tick();
      vectors++; if (p2_hp_now !== 8'd0 || last_damage !== 8'd0) begin errors++; $display("FAIL arst_idle got hp %0d dmg %0d exp 0/0", p2_hp_now, last_damage); end
      enter_fight();
      vectors++; if (p2_hp_now !== 8'd60) begin errors++; $display("FAIL arst_reload got %0d exp 60", p2_hp_now); end
   endtask

   task automatic test_timeout();
      common_stats();
      enter_fight();
`ifdef FIGHT_TURN_TIMEOUT_EN
      repeat (21) tick();
      vectors++; if (p2_hp_now !== 8'd60) begin errors++; $display("FAIL tmo_early got %0d exp 60", p2_hp_now); end
      tick();
      vectors++; if (p2_hp_now !== 8'd30 || last_damage !== 8'd30) begin errors++; $display("FAIL tmo_apply got hp %0d dmg %0d exp 30/30", p2_hp_now, last_damage); end
      tick();
      vectors++; if (turn !== 1'b1) begin errors++; $display("FAIL tmo_turn got %0d exp 1", turn); end
`else
      repeat (1000) tick();
      vectors++; if (p2_hp_now !== 8'd60 || last_damage !== 8'd0) begin errors++; $display("FAIL notmo_hold got hp %0d dmg %0d exp 60/0", p2_hp_now, last_damage); end
      vectors++; if (turn !== 1'b0 || fight_done !== 1'b0) begin errors++; $display("FAIL notmo_state got turn %0d done %0d exp 0/0", turn, fight_done); end
`endif
   endtask

   task automatic test_random_battles();
      logic l, r;
      for (int b = 0; b < 30; b++) begin
         p1_pokemon_hp = 8'($urandom_range(1, 255));  p2_pokemon_hp = 8'($urandom_range(1, 255));
         p1_pokemon_speed = 8'($urandom_range(0, 3)); p2_pokemon_speed = 8'($urandom_range(0, 3));
         p1_skill_1_damage = 8'($urandom_range(0, 120)); p1_skill_2_damage = 8'($urandom_range(0, 120));
         p1_skill_3_damage = 8'($urandom_range(0, 120)); p2_skill_1_damage = 8'($urandom_range(0, 120));
         p2_skill_2_damage = 8'($urandom_range(0, 120)); p2_skill_3_damage = 8'($urandom_range(0, 120));
         enter_fight();
         m_load();
         vectors++; if (turn !== m_turn || p1_hp_now !== m_hp1 || p2_hp_now !== m_hp2) begin errors++; $display("FAIL rnd_load got t%0d %0d/%0d exp t%0d %0d/%0d", turn, p1_hp_now, p2_hp_now, m_turn, m_hp1, m_hp2); end
         p1_skill_1_damage = 8'($urandom); p2_skill_1_damage = 8'($urandom);
         p1_pokemon_hp = 8'($urandom); p2_pokemon_speed = 8'($urandom);
         for (int t = 0; t < 30 && !m_done; t++) begin
            repeat ($urandom_range(0, 6)) begin
               l = 1'($urandom); r = 1'($urandom);
               m_move(l, r);
               press(0, l, r);
            end
            vectors++; if (skill_sel !== m_sel) begin errors++; $display("FAIL rnd_sel got %0d exp %0d", skill_sel, m_sel); end
            press(1, 1'($urandom), 1'($urandom));
            m_attack();
            press(0, 1'($urandom), 1'($urandom));
            vectors++; if (p1_hp_now !== m_hp1 || p2_hp_now !== m_hp2 || last_damage !== m_last) begin errors++; $display("FAIL rnd_apply got %0d/%0d d%0d exp %0d/%0d d%0d", p1_hp_now, p2_hp_now, last_damage, m_hp1, m_hp2, m_last); end
            tick();
            vectors++; if (turn !== m_turn || fight_done !== m_done || winner !== m_winner || skill_sel !== m_sel) begin errors++; $display("FAIL rnd_check got t%0d d%0d w%0d s%0d exp t%0d d%0d w%0d s%0d", turn, fight_done, winner, skill_sel, m_turn, m_done, m_winner, m_sel); end
         end
      end
   endtask

   initial begin
      common_stats();
      test_reset();
      test_full_battle();
      test_abort();
      test_speed_tie();
      test_skill_wrap();
      test_async_reset();
      test_timeout();
      test_random_battles();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
